chroma_filter_mode_sequencer: RTL and testbench



---
 rtl/chroma_filter_pkg.sv | 24 ++
 rtl/chroma_filter_mode_sequencer.sv | 108 ++++++++++
 tb/tb_chroma_filter_mode_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/chroma_filter_pkg.sv
// Shared types and mode constants for the composite encoder's chroma carrier filter path.
package chroma_filter_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_BLANK = 3'd1,
    FLUSH      = 3'd2,
    SWITCH     = 3'd3,
    SETTLE     = 3'd4
  } state_e;

  localparam logic MODE_NTSC = 1'b0;
  localparam logic MODE_PAL  = 1'b1;

  // Live video only flows while no coefficient change is in progress.
  function automatic logic passes_video(input state_e s);
    return (s == IDLE) || (s == WAIT_BLANK);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/chroma_filter_mode_sequencer.sv
// Switches the carrier filter's PAL/NTSC coefficients in vblank after a zero flush, then blanks output while it settles.
// All outputs registered, 1-cycle datapath latency; no backpressure (level-sensitive request and blanking inputs).
module chroma_filter_mode_sequencer
  import chroma_filter_pkg::*;
#(
  parameter int   FLUSH_CYCLES  = 64,
  parameter int   SETTLE_CYCLES = 16,
  parameter logic PAL_AT_RESET  = MODE_PAL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_req,
  input  logic              vblank,
  input  logic signed [7:0] sample_in,
  output logic signed [7:0] filter_in,
  output logic              pal_mode,
  input  logic signed [7:0] filter_out,
  output logic signed [7:0] video_out,
  output logic              busy,
  output logic              switch_done
);

  localparam int CNT_W = $clog2(max_int(FLUSH_CYCLES, SETTLE_CYCLES) + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               target_q, target_d;
  logic               pal_q, pal_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic signed [7:0]  filter_in_q, filter_in_d;
  logic signed [7:0]  video_q, video_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    pal_d       = pal_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mode_req != pal_q) state_d = WAIT_BLANK;
      end
      WAIT_BLANK: begin
        if (mode_req == pal_q) begin
          state_d = IDLE;
        end else if (vblank) begin
          target_d = mode_req;
          cnt_d    = CNT_W'(FLUSH_CYCLES - 1);
          state_d  = FLUSH;
        end
      end
      FLUSH: begin
        // Zero check precedes the decrement, so the counter never wraps.
        if (cnt_q == '0) state_d = SWITCH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      SWITCH: begin
        pal_d   = target_q;
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d      = (state_d != IDLE);
    filter_in_d = passes_video(state_q) ? sample_in  : 8'sd0;
    video_d     = passes_video(state_q) ? filter_out : 8'sd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      target_q    <= PAL_AT_RESET;
      pal_q       <= PAL_AT_RESET;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      filter_in_q <= 8'sd0;
      video_q     <= 8'sd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      pal_q       <= pal_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      filter_in_q <= filter_in_d;
      video_q     <= video_d;
    end
  end

  assign filter_in   = filter_in_q;
  assign pal_mode    = pal_q;
  assign video_out   = video_q;
  assign busy        = busy_q;
  assign switch_done = done_q;

endmodule

// File: tb/tb_chroma_filter_mode_sequencer.sv
// Directed bench for the chroma filter mode sequencer, with a one-tap carrier filter stand-in on filter_in/pal_mode.
module tb_chroma_filter_mode_sequencer;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode_req;
  logic              vblank;
  logic signed [7:0] sample_in;
  logic signed [7:0] filter_in;
  logic              pal_mode;
  logic signed [7:0] filter_out;
  logic signed [7:0] video_out;
  logic              busy;
  logic              switch_done;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  chroma_filter_mode_sequencer #(
    .FLUSH_CYCLES (64),
    .SETTLE_CYCLES(16),
    .PAL_AT_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode_req   (mode_req),
    .vblank     (vblank),
    .sample_in  (sample_in),
    .filter_in  (filter_in),
    .pal_mode   (pal_mode),
    .filter_out (filter_out),
    .video_out  (video_out),
    .busy       (busy),
    .switch_done(switch_done)
  );

  always #5 clk = ~clk;

  // Carrier filter stand-in: registered, passes in PAL, negates in NTSC.
  always @(posedge clk) begin
    if (reset) filter_out <= 8'sd0;
    else       filter_out <= pal_mode ? filter_in : -filter_in;
  end

  always @(negedge clk) begin
    if (switch_done) done_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    mode_req  = 1'b1;
    vblank    = 1'b0;
    sample_in = 8'sd37;

    // Reset state
    step(2);
    check("rst_pal", pal_mode, 8'd1);
    check("rst_filter_in", filter_in, 8'd0);
    check("rst_video", video_out, 8'd0);
    check("rst_busy", busy, 8'd0);
    check("rst_done", switch_done, 8'd0);

    // Steady PAL pass-through
    reset = 1'b0;
    step(1);
    check("idle_filter_in", filter_in, 8'd37);
    check("idle_busy", busy, 8'd0);
    step(2);
    check("idle_video", video_out, 8'd37);
    check("idle_no_done", 8'(done_cnt), 8'd0);

    // Request NTSC, wait 100 cycles outside vblank
    mode_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      check("wait_busy", busy, 8'd1);
    end
    check("wait_filter_in", filter_in, 8'd37);
    check("wait_pal", pal_mode, 8'd1);

    // vblank: k=1 is the first FLUSH cycle
    vblank    = 1'b1;
    sample_in = -8'sd20;
    step(1);
    check("flush1_filter_in", filter_in, 8'hEC);
    check("flush1_video", video_out, 8'd37);
    check("flush1_busy", busy, 8'd1);
    for (int k = 2; k <= 86; k++) begin
      step(1);
      if (k == 10) vblank = 1'b0;
      if (k <= 82) begin
        check("seq_video_blank", video_out, 8'd0);
        check("seq_filter_in_zero", filter_in, 8'd0);
      end
      if (k <= 81) check("seq_busy", busy, 8'd1);
      if (k == 65) check("switch_pal_old", pal_mode, 8'd1);
      if (k == 66) check("settle_pal_new", pal_mode, 8'd0);
      if (k >= 81 && k <= 83) check("seq_done", switch_done, (k == 82) ? 8'd1 : 8'd0);
      if (k == 82) check("seq_idle_busy", busy, 8'd0);
      if (k == 83) check("post_filter_in", filter_in, 8'hEC);
      if (k == 84) check("post_filter_out", filter_out, 8'd20);
      if (k == 85) check("post_video", video_out, 8'd20);
      if (k == 86) check("post_no_restart", busy, 8'd0);
    end
    check("seq_done_count", 8'(done_cnt), 8'd1);

    // Withdrawn request returns to IDLE without switching
    mode_req = 1'b1;
    reset    = 1'b1;
    step(1);
    reset = 1'b0;
    check("wd_pal_reset", pal_mode, 8'd1);
    mode_req = 1'b0;
    step(1);
    check("wd_busy", busy, 8'd1);
    step(3);
    mode_req = 1'b1;
    step(1);
    check("wd_idle", busy, 8'd0);
    step(3);
    check("wd_pal", pal_mode, 8'd1);
    check("wd_busy_stays", busy, 8'd0);
    check("wd_no_done", 8'(done_cnt), 8'd1);

    // mode_req toggling during FLUSH is ignored; target stays NTSC
    mode_req = 1'b0;
    vblank   = 1'b1;
    step(2);
    for (int k = 2; k <= 84; k++) begin
      step(1);
      if (k == 5)  mode_req = 1'b1;
      if (k == 20) mode_req = 1'b0;
      if (k == 30) mode_req = 1'b1;
      if (k == 45) mode_req = 1'b0;
      if (k == 65) check("tg_switch_pal", pal_mode, 8'd1);
      if (k == 66) check("tg_settle_pal", pal_mode, 8'd0);
      if (k == 81) check("tg_busy", busy, 8'd1);
      if (k == 82) check("tg_done", switch_done, 8'd1);
      if (k == 84) check("tg_no_restart", busy, 8'd0);
    end
    check("tg_done_count", 8'(done_cnt), 8'd2);

    // Reset mid-SETTLE aborts back to PAL
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    step(70);
    check("ab_busy_pre", busy, 8'd1);
    check("ab_pal_pre", pal_mode, 8'd0);
    mode_req = 1'b1;
    reset    = 1'b1;
    step(1);
    check("ab_pal", pal_mode, 8'd1);
    check("ab_busy", busy, 8'd0);
    check("ab_video", video_out, 8'd0);
    check("ab_done", switch_done, 8'd0);
    reset = 1'b0;
    step(3);
    check("ab_stay_idle", busy, 8'd0);
    check("ab_done_count", 8'(done_cnt), 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
